// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 field widths, classification helpers and checker state enum
package fp16_pkg;

    localparam int FP16_W      = 16;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    function automatic logic fp16_is_nan(input logic [FP16_W-1:0] x);
        return (&x[FP16_FRAC_W +: FP16_EXP_W]) && (|x[FP16_FRAC_W-1:0]);
    endfunction

    function automatic logic fp16_is_inf(input logic [FP16_W-1:0] x);
        return (&x[FP16_FRAC_W +: FP16_EXP_W]) && !(|x[FP16_FRAC_W-1:0]);
    endfunction

    function automatic logic fp16_is_zero(input logic [FP16_W-1:0] x);
        return ~|x[FP16_W-2:0];
    endfunction

    // Any NaN pair matches, any zero pair matches, Inf or a lone NaN needs
    // bit equality, everything else is a same-sign magnitude distance test.
    function automatic logic fp16_match(input logic [FP16_W-1:0] e,
                                        input logic [FP16_W-1:0] g,
                                        input logic [3:0]        tol);
        logic [FP16_W-2:0] diff;
        logic              m;
        diff = (e[FP16_W-2:0] >= g[FP16_W-2:0]) ? (e[FP16_W-2:0] - g[FP16_W-2:0])
                                                 : (g[FP16_W-2:0] - e[FP16_W-2:0]);
        if (fp16_is_nan(e) && fp16_is_nan(g))
            m = 1'b1;
        else if (fp16_is_zero(e) && fp16_is_zero(g))
            m = 1'b1;
        else if (fp16_is_nan(e) || fp16_is_nan(g) || fp16_is_inf(e) || fp16_is_inf(g))
            m = (e == g);
        else
            m = (e[FP16_W-1] == g[FP16_W-1]) && (diff <= {11'd0, tol});
        return m;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [6:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {10'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/fp16_result_checker_if.sv
// rtl/fp16_result_checker_if.sv - expected-value and FPU-result streams into the checker
interface fp16_result_checker_if;
    import fp16_pkg::*;

    logic              exp_valid;
    logic [FP16_W-1:0] exp_data;
    logic              exp_ready;
    logic              res_valid;
    logic [FP16_W-1:0] res_data;

    modport master (
        output exp_valid, exp_data, res_valid, res_data,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_data, res_valid, res_data,
        output exp_ready
    );

endinterface

// File: rtl/fp16_sync_fifo.sv
// rtl/fp16_sync_fifo.sv - first-word-fall-through FIFO holding expected FP16 values
module fp16_sync_fifo
    import fp16_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = FP16_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp16_result_checker.sv
// rtl/fp16_result_checker.sv - scoreboards FPU results against queued expected FP16 values
module fp16_result_checker
    import fp16_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp16_result_checker_if.slave  chk_if,
    input  logic [3:0]            ulp_tol,
    input  logic                  done_req,
    output logic [15:0]           pass_cnt,
    output logic [15:0]           fail_cnt,
    output logic [15:0]           first_fail_idx,
    output logic [15:0]           first_fail_got,
    output logic [15:0]           first_fail_exp,
    output logic                  underflow,
    output logic                  done,
    output logic                  pass
);

    localparam int CW = $clog2(DEPTH) + 1;

    chk_state_t    state_q;
    chk_state_t    state_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [15:0]   fifo_head;
    logic          accepting;
    logic          comparing;
    logic          push_acc;
    logic          pop_acc;
    logic          drain_last;
    logic          drain_timeout;
    logic [15:0]   drain_cnt_q;
    logic [15:0]   res_idx_q;
    logic          cmp_valid_q;
    logic          cmp_match_q;
    logic [15:0]   cmp_got_q;
    logic [15:0]   cmp_exp_q;
    logic [15:0]   cmp_idx_q;
    logic          fail_seen_q;
    logic [6:0]    leftover;
    logic [6:0]    fail_inc;

    assign accepting        = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign comparing        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign chk_if.exp_ready = !fifo_full;
    assign push_acc         = chk_if.exp_valid && !fifo_full && accepting;
    assign pop_acc          = chk_if.res_valid && !fifo_empty && comparing;
    assign drain_last       = (drain_cnt_q == 16'(TIMEOUT - 1));
    assign drain_timeout    = (state_q == ST_DRAIN) && !fifo_empty && drain_last;
    // Entries still queued after this cycle's pop never got a result.
    assign leftover         = 7'(fifo_count) - {6'd0, pop_acc};
    assign fail_inc         = (drain_timeout ? leftover : 7'd0)
                            + {6'd0, cmp_valid_q && !cmp_match_q};
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (fail_cnt == 16'd0) && !underflow;

    fp16_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FP16_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_acc),
        .push_data (chk_if.exp_data),
        .pop       (pop_acc),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: leave IDLE on first activity, drain on request, DONE is terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (push_acc || chk_if.res_valid) state_d = ST_RUN;
            ST_RUN:   if (done_req) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty || drain_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Cycles spent waiting in DRAIN for the outstanding results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drain_cnt_q <= '0;
        else if (state_q == ST_DRAIN)
            drain_cnt_q <= drain_cnt_q + 16'd1;
        else
            drain_cnt_q <= '0;
    end

    // Compare stage: verdict and operands registered at the popping edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid_q <= 1'b0;
            cmp_match_q <= 1'b0;
            cmp_got_q   <= '0;
            cmp_exp_q   <= '0;
            cmp_idx_q   <= '0;
            res_idx_q   <= '0;
        end else begin
            cmp_valid_q <= pop_acc;
            if (pop_acc) begin
                cmp_match_q <= fp16_match(fifo_head, chk_if.res_data, ulp_tol);
                cmp_got_q   <= chk_if.res_data;
                cmp_exp_q   <= fifo_head;
                cmp_idx_q   <= res_idx_q;
                res_idx_q   <= res_idx_q + 16'd1;
            end
        end
    end

    // Scoreboard: saturating counters, first-mismatch capture, sticky underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            first_fail_exp <= '0;
            fail_seen_q    <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            pass_cnt <= sat_add16(pass_cnt, {6'd0, cmp_valid_q && cmp_match_q});
            fail_cnt <= sat_add16(fail_cnt, fail_inc);
            if (cmp_valid_q && !cmp_match_q && !fail_seen_q) begin
                fail_seen_q    <= 1'b1;
                first_fail_idx <= cmp_idx_q;
                first_fail_got <= cmp_got_q;
                first_fail_exp <= cmp_exp_q;
            end
            if (chk_if.res_valid && fifo_empty && (state_q != ST_DONE))
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp16_result_checker.sv
// tb/tb_fp16_result_checker.sv - self-checking bench for fp16_result_checker
module tb_fp16_result_checker;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ulp_tol = 4'd0;
    logic        done_req = 1'b0;
    logic [15:0] pass_cnt, fail_cnt, first_fail_idx, first_fail_got, first_fail_exp;
    logic        underflow, done, pass;

    int checks = 0;
    int failures = 0;

    fp16_result_checker_if ifc();

    fp16_result_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .chk_if         (ifc),
        .ulp_tol        (ulp_tol),
        .done_req       (done_req),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_got (first_fail_got),
        .first_fail_exp (first_fail_exp),
        .underflow      (underflow),
        .done           (done),
        .pass           (pass)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] mq[$];
    int          m_phase;
    int          m_pass, m_fail, m_idx, m_ff_idx, m_ff_got, m_ff_exp;
    bit          m_under, m_seen;

    function automatic bit ref_match(int e, int g, int tol);
        int ee, ef, ge, gf, d;
        ee = (e >> 10) & 31; ef = e & 1023;
        ge = (g >> 10) & 31; gf = g & 1023;
        if (ee == 31 && ef != 0 && ge == 31 && gf != 0) return 1;
        if ((e & 'h7FFF) == 0 && (g & 'h7FFF) == 0) return 1;
        if (ee == 31 || ge == 31) return e == g;
        if ((e >> 15) != (g >> 15)) return 0;
        d = (e & 'h7FFF) - (g & 'h7FFF);
        if (d < 0) d = -d;
        return d <= tol;
    endfunction

    function automatic logic [15:0] special_val();
        case ($urandom_range(0, 5))
            0: return 16'h7C00;
            1: return 16'hFC00;
            2: return 16'h7E00;
            3: return 16'h0000;
            4: return 16'h8000;
            default: return 16'hFD55;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        m_phase = 0; m_pass = 0; m_fail = 0; m_idx = 0;
        m_ff_idx = 0; m_ff_got = 0; m_ff_exp = 0;
        m_under = 0; m_seen = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.exp_valid = 1'b0; ifc.exp_data = '0;
        ifc.res_valid = 1'b0; ifc.res_data = '0;
        done_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic step(input logic ev, input logic [15:0] ed, input logic rv,
                        input logic [15:0] rd, input logic dr);
        int          qsz;
        bit          push;
        logic [15:0] e;
        qsz  = mq.size();
        push = ev && (qsz < DEPTH) && (m_phase <= 1);
        if (rv && m_phase != 3) begin
            if (qsz == 0) m_under = 1;
            else if (m_phase == 1 || m_phase == 2) begin
                e = mq.pop_front();
                if (ref_match(e, rd, ulp_tol)) m_pass++;
                else begin
                    m_fail++;
                    if (!m_seen) begin
                        m_seen = 1; m_ff_idx = m_idx; m_ff_got = rd; m_ff_exp = e;
                    end
                end
                m_idx++;
            end
        end
        if (push) mq.push_back(ed);
        if (m_phase == 0 && (push || rv)) m_phase = 1;
        else if (m_phase == 1 && dr) m_phase = 2;
        ifc.exp_valid = ev; ifc.exp_data = ed;
        ifc.res_valid = rv; ifc.res_data = rd;
        done_req = dr;
        @(posedge clk);
        #1;
        ifc.exp_valid = 1'b0; ifc.res_valid = 1'b0; done_req = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int cyc);
        ok = 0; cyc = 0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            if (done === 1'b1) begin ok = 1; break; end
            step(0, 16'h0, 0, 16'h0, 0);
            cyc++;
        end
        if (done === 1'b1) ok = 1;
        m_fail += mq.size();
        mq.delete();
        m_phase = 3;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pass_cnt !== 16'd0) begin failures++; $display("FAIL reset_pass_cnt got=%h exp=0000", pass_cnt); end
        checks++; if (fail_cnt !== 16'd0) begin failures++; $display("FAIL reset_fail_cnt got=%h exp=0000", fail_cnt); end
        checks++; if (first_fail_idx !== 16'd0 || first_fail_got !== 16'd0 || first_fail_exp !== 16'd0) begin
            failures++; $display("FAIL reset_first_fail got=%h/%h/%h exp=0000/0000/0000", first_fail_idx, first_fail_got, first_fail_exp); end
        checks++; if ({underflow, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {underflow, done, pass}); end
        checks++; if (ifc.exp_ready !== 1'b1) begin failures++; $display("FAIL reset_exp_ready got=%b exp=1", ifc.exp_ready); end
    endtask

    task automatic test_basic();
        bit ok; int cyc;
        do_reset(); ulp_tol = 4'd0;
        step(1, 16'h3C00, 0, 16'h0, 0);
        step(1, 16'h4000, 0, 16'h0, 0);
        step(0, 16'h0, 1, 16'h3C00, 0);
        step(0, 16'h0, 1, 16'h4000, 0);
        step(0, 16'h0, 0, 16'h0, 1);
        wait_done(ok, cyc);
        checks++; if (!ok) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (pass_cnt !== 16'd2) begin failures++; $display("FAIL basic_pass_cnt got=%0d exp=2", pass_cnt); end
        checks++; if (fail_cnt !== 16'd0) begin failures++; $display("FAIL basic_fail_cnt got=%0d exp=0", fail_cnt); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL basic_pass got=%b exp=1", pass); end
    endtask

    task automatic test_ulp_latency();
        bit ok; int cyc;
        do_reset(); ulp_tol = 4'd1;
        step(1, 16'h3C00, 0, 16'h0, 0);
        step(1, 16'h3C00, 0, 16'h0, 0);
        step(0, 16'h0, 1, 16'h3C01, 0);
        step(0, 16'h0, 1, 16'h3C02, 0);
        checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
            failures++; $display("FAIL ulp_latency got=%0d/%0d exp=1/0", pass_cnt, fail_cnt); end
        step(0, 16'h0, 0, 16'h0, 0);
        checks++; if (fail_cnt !== 16'd1) begin failures++; $display("FAIL ulp_fail_cnt got=%0d exp=1", fail_cnt); end
        checks++; if (first_fail_idx !== 16'd1 || first_fail_got !== 16'h3C02 || first_fail_exp !== 16'h3C00) begin
            failures++; $display("FAIL ulp_first_fail got=%h/%h/%h exp=0001/3c02/3c00", first_fail_idx, first_fail_got, first_fail_exp); end
        step(0, 16'h0, 0, 16'h0, 1);
        wait_done(ok, cyc);
        checks++; if (!ok || pass !== 1'b0) begin failures++; $display("FAIL ulp_pass got=%b/%b exp=1/0", ok, pass); end
    endtask

    task automatic test_special();
        bit ok; int cyc;
        do_reset(); ulp_tol = 4'd15;
        step(1, 16'h7E00, 0, 16'h0, 0);
        step(1, 16'h0000, 0, 16'h0, 0);
        step(1, 16'h7C00, 0, 16'h0, 0);
        step(0, 16'h0, 1, 16'hFC01, 0);
        step(0, 16'h0, 1, 16'h8000, 0);
        step(0, 16'h0, 1, 16'h7BFF, 0);
        step(0, 16'h0, 0, 16'h0, 1);
        wait_done(ok, cyc);
        checks++; if (!ok || pass_cnt !== 16'd2 || fail_cnt !== 16'd1) begin
            failures++; $display("FAIL special_counts got=%0d/%0d exp=2/1", pass_cnt, fail_cnt); end
        checks++; if (first_fail_idx !== 16'd2 || first_fail_got !== 16'h7BFF || first_fail_exp !== 16'h7C00) begin
            failures++; $display("FAIL special_first_fail got=%h/%h/%h exp=0002/7bff/7c00", first_fail_idx, first_fail_got, first_fail_exp); end
    endtask

    task automatic test_underflow();
        bit ok; int cyc;
        do_reset(); ulp_tol = 4'd0;
        step(0, 16'h0, 1, 16'h3C00, 0);
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag got=%b exp=1", underflow); end
        step(0, 16'h0, 0, 16'h0, 1);
        wait_done(ok, cyc);
        checks++; if (!ok || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || pass !== 1'b0) begin
            failures++; $display("FAIL underflow_done got=%b/%0d/%0d/%b exp=1/0/0/0", ok, pass_cnt, fail_cnt, pass); end
    endtask

    task automatic test_no_bypass();
        do_reset(); ulp_tol = 4'd0;
        step(1, 16'h3C00, 1, 16'h3C00, 0);
        step(0, 16'h0, 1, 16'h3C00, 0);
        step(1, 16'h4000, 0, 16'h0, 0);
        step(0, 16'h0, 1, 16'h0000, 0);
        step(0, 16'h0, 0, 16'h0, 0);
        checks++; if (underflow !== 1'b1 || pass_cnt !== 16'd1 || fail_cnt !== 16'd1) begin
            failures++; $display("FAIL no_bypass_counts got=%b/%0d/%0d exp=1/1/1", underflow, pass_cnt, fail_cnt); end
        checks++; if (first_fail_idx !== 16'd1 || first_fail_got !== 16'h0000 || first_fail_exp !== 16'h4000) begin
            failures++; $display("FAIL no_bypass_index got=%h/%h/%h exp=0001/0000/4000", first_fail_idx, first_fail_got, first_fail_exp); end
    endtask

    task automatic test_timeout();
        bit ok; int cyc;
        do_reset(); ulp_tol = 4'd0;
        step(1, 16'h3C00, 0, 16'h0, 0);
        step(1, 16'h4000, 0, 16'h0, 0);
        step(1, 16'h4200, 0, 16'h0, 0);
        step(0, 16'h0, 1, 16'h3C00, 0);
        step(0, 16'h0, 0, 16'h0, 1);
        wait_done(ok, cyc);
        checks++; if (!ok || cyc != TIMEOUT) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", cyc, TIMEOUT); end
        checks++; if (fail_cnt !== 16'd2 || pass_cnt !== 16'd1) begin
            failures++; $display("FAIL timeout_counts got=%0d/%0d exp=1/2", pass_cnt, fail_cnt); end
        step(1, 16'h1234, 1, 16'h5555, 0);
        step(0, 16'h0, 1, 16'h3C00, 0);
        step(0, 16'h0, 0, 16'h0, 0);
        checks++; if (done !== 1'b1 || underflow !== 1'b0 || pass_cnt !== 16'd1 || fail_cnt !== 16'd2) begin
            failures++; $display("FAIL done_hold got=%b/%b/%0d/%0d exp=1/0/1/2", done, underflow, pass_cnt, fail_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc;
        logic [15:0] v [7];
        do_reset(); ulp_tol = 4'd0;
        for (int i = 0; i < 7; i++) v[i] = 16'h3800 + 16'(i * 37);
        step(1, v[0], 0, 16'h0, 0);
        for (int i = 1; i < 7; i++) step(1, v[i], 1, v[i-1], 0);
        checks++; if (ifc.exp_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ifc.exp_ready); end
        step(0, 16'h0, 1, v[6], 0);
        step(0, 16'h0, 0, 16'h0, 1);
        wait_done(ok, cyc);
        checks++; if (!ok || pass_cnt !== 16'd7 || fail_cnt !== 16'd0 || underflow !== 1'b0) begin
            failures++; $display("FAIL b2b_counts got=%0d/%0d/%b exp=7/0/0", pass_cnt, fail_cnt, underflow); end
    endtask

    task automatic test_full_reset();
        bit ok; int cyc;
        do_reset(); ulp_tol = 4'd0;
        step(1, 16'h3C00, 0, 16'h0, 0);
        step(0, 16'h0, 1, 16'h3C01, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 16'h4400 + 16'(i), 0, 16'h0, 0);
        checks++; if (ifc.exp_ready !== 1'b0 || fail_cnt !== 16'd1) begin
            failures++; $display("FAIL full_ready got=%b/%0d exp=0/1", ifc.exp_ready, fail_cnt); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || first_fail_idx !== 16'd0 ||
                      first_fail_got !== 16'd0 || first_fail_exp !== 16'd0) begin
            failures++; $display("FAIL async_reset_counts got=%0d/%0d/%h/%h/%h exp=0", pass_cnt, fail_cnt, first_fail_idx, first_fail_got, first_fail_exp); end
        checks++; if ({underflow, done, pass, ifc.exp_ready} !== 4'b0001) begin
            failures++; $display("FAIL async_reset_flags got=%b exp=0001", {underflow, done, pass, ifc.exp_ready}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        step(1, 16'h5000, 0, 16'h0, 0);
        step(0, 16'h0, 1, 16'h5000, 0);
        step(0, 16'h0, 0, 16'h0, 1);
        wait_done(ok, cyc);
        checks++; if (!ok || pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || pass !== 1'b1) begin
            failures++; $display("FAIL post_reset_fresh got=%b/%0d/%0d/%b exp=1/1/0/1", ok, pass_cnt, fail_cnt, pass); end
    endtask

    task automatic test_random();
        bit ok; int cyc;
        logic ev, rv;
        logic [15:0] ed, rd;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            ulp_tol = 4'($urandom_range(0, 3));
            step(1, 16'($urandom), 0, 16'h0, 0);
            for (int c = 0; c < 150; c++) begin
                ev = ($urandom_range(0, 9) < 6);
                ed = ($urandom_range(0, 7) == 0) ? special_val() : 16'($urandom);
                rv = ($urandom_range(0, 1) == 1);
                if (mq.size() > 0 && $urandom_range(0, 7) != 0)
                    rd = mq[0] + 16'($urandom_range(0, 6)) - 16'd3;
                else
                    rd = special_val();
                step(ev, ed, rv, rd, 0);
                checks++; if (ifc.exp_ready !== (mq.size() < DEPTH)) begin
                    failures++; $display("FAIL rand_ready it=%0d c=%0d got=%b exp=%b", it, c, ifc.exp_ready, mq.size() < DEPTH); end
            end
            step(0, 16'h0, 0, 16'h0, 1);
            wait_done(ok, cyc);
            checks++; if (!ok) begin failures++; $display("FAIL rand_done it=%0d got=%b exp=1", it, done); end
            checks++; if (pass_cnt !== 16'(m_pass) || fail_cnt !== 16'(m_fail)) begin
                failures++; $display("FAIL rand_counts it=%0d got=%0d/%0d exp=%0d/%0d", it, pass_cnt, fail_cnt, m_pass, m_fail); end
            checks++; if (underflow !== m_under || pass !== (m_fail == 0 && !m_under)) begin
                failures++; $display("FAIL rand_flags it=%0d got=%b/%b exp=%b/%b", it, underflow, pass, m_under, m_fail == 0 && !m_under); end
            checks++; if (first_fail_idx !== 16'(m_ff_idx) || first_fail_got !== 16'(m_ff_got) || first_fail_exp !== 16'(m_ff_exp)) begin
                failures++; $display("FAIL rand_first_fail it=%0d got=%h/%h/%h exp=%h/%h/%h", it,
                    first_fail_idx, first_fail_got, first_fail_exp, 16'(m_ff_idx), 16'(m_ff_got), 16'(m_ff_exp)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ulp_latency();
        test_special();
        test_underflow();
        test_no_bypass();
        test_timeout();
        test_back_to_back();
        test_full_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp16_result_checker.md
FP16_RESULT_CHECKER -- requirements
Module: fp16_result_checker

Interface
REQ-001 Parameter DEPTH, default 8, expected-value FIFO entries (power of two, 2..64).
REQ-002 Parameter TIMEOUT, default 256, drain-phase cycle limit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 exp_valid  input  1  expected result offered by stimulus side.
REQ-006 exp_data  input  16  expected FP16 result (sign/5-bit exp/10-bit frac).
REQ-007 exp_ready  output  1  FIFO can accept; equals not-full.
REQ-008 res_valid  input  1  FPU result strobe; no backpressure.
REQ-009 res_data  input  16  FP16 result from FPU output O.
REQ-010 ulp_tol  input  4  allowed magnitude difference in ULPs.
REQ-011 done_req  input  1  stimulus finished; begin drain.
REQ-012 pass_cnt  output  16  matched results.
REQ-013 fail_cnt  output  16  mismatches plus missing results.
REQ-014 first_fail_idx  output  16  result index (0-based) of first mismatch.
REQ-015 first_fail_got / first_fail_exp  output  16 each  operands of first mismatch.
REQ-016 underflow  output  1  sticky: result arrived with FIFO empty.
REQ-017 done  output  1  check complete; pass  output  1  valid when done.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on first accepted push or res_valid.
REQ-019 RUN->DRAIN when done_req=1; DRAIN->DONE when FIFO empty or drain counter reaches TIMEOUT-1; DONE holds until reset.
REQ-020 Push when exp_valid&&exp_ready in IDLE/RUN; pushes ignored in DRAIN/DONE.
REQ-021 Pop when res_valid in RUN/DRAIN with FIFO non-empty; simultaneous push and pop both take effect, occupancy unchanged.
REQ-022 res_valid with FIFO empty (including same-cycle first push; no bypass): set underflow, no counter change, index not advanced.
REQ-023 Compare: both NaN (exp=31, frac!=0) -> match regardless of payload/sign.
REQ-024 Compare: both zero (+0/-0 any mix) -> match.
REQ-025 Compare: Inf or one NaN -> exact 16-bit equality required.
REQ-026 Compare otherwise: signs equal and |mag(exp)-mag(got)| <= ulp_tol (15-bit unsigned magnitude subtraction) -> match, else mismatch.
REQ-027 Compare is registered: counters/first_fail_* update exactly 1 cycle after the popping edge.
REQ-028 first_fail_* captured only on the first mismatch; held thereafter.
REQ-029 On DRAIN timeout, remaining FIFO occupancy added to fail_cnt in the DRAIN->DONE transition cycle.
REQ-030 All counters saturate at 16'hFFFF; result index wraps.
REQ-031 pass = (fail_cnt==0) && !underflow; done=1 in DONE only.
REQ-032 res_valid in IDLE with FIFO empty sets underflow; in DONE ignored.

Reset
REQ-033 rst_n low: FSM=IDLE, FIFO empty, exp_ready=1, all counters/first_fail_*/underflow/done/pass=0, immediately and independent of clk.
REQ-034 Reset mid-RUN/DRAIN discards FIFO contents and in-flight compare; no partial count survives.

Structure
REQ-035 Shared package fp16_pkg holds FP16 field widths, NaN/Inf/zero classification functions and FSM state enum.
REQ-036 FIFO is one sub-module, fp16_sync_fifo (DEPTH-parameterised, full/empty/count outputs).

Verification
REQ-037 Push 0x3C00,0x4000; results 0x3C00,0x4000; done_req -> DONE, pass_cnt=2, fail_cnt=0, pass=1.
REQ-038 ulp_tol=1: exp 0x3C00, got 0x3C01 -> match; got 0x3C02 -> fail_cnt=1, first_fail_idx=1, got=0x3C02, exp=0x3C00.
REQ-039 exp 0x7E00 got 0xFC01 -> match; exp 0x0000 got 0x8000 -> match; exp 0x7C00 got 0x7BFF (ulp_tol=15) -> fail.
REQ-040 res_valid=1 with 0x3C00 before any push -> underflow=1, counters 0, pass=0 at DONE.
REQ-041 Push 3, return 1, done_req -> DONE after TIMEOUT cycles, fail_cnt=2.
REQ-042 Fill DEPTH entries -> exp_ready=0; assert rst_n=0 mid-RUN -> all outputs 0, exp_ready=1 asynchronously.
